hard_llr_seq: RTL and testbench

- Sequential hard-decision-to-LLR mapper for VT-coded DNA strands, with a built-in Varashamov-Tenengolts checksum check.
- Walks the active bits of a received word one per cycle and accumulates the VT checksum sum((i+1)*x_i) mod (len+1).
- Writes a signed fixed-point LLR per bit; in weighted mode, confidence is reduced when the checksum fails.
- Sits between the hard decoder and the soft-decision stages, replacing the fixed-delay wrapper with a real start/busy/done handshake.

---
 rtl/hard_llr_seq_pkg.sv | 15 +
 rtl/hard_llr_seq_if.sv | 22 ++
 rtl/hard_llr_seq_vt_mod_acc.sv | 26 ++
 rtl/hard_llr_seq.sv | 98 +++++++++
 tb/tb_hard_llr_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/hard_llr_seq_pkg.sv
// hard_llr_pkg: shared FSM states, LLR magnitudes and sign helpers for the hard-to-LLR mapper
package hard_llr_pkg;
  localparam int LLR_W = 32;
  localparam int FRAC_W = 23;
  localparam int LO_SHIFT = 2;
  localparam logic signed [LLR_W-1:0] MAG_HI = LLR_W'(1) << FRAC_W;
  localparam logic signed [LLR_W-1:0] MAG_LO = MAG_HI >>> LO_SHIFT;
  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, DONE} state_t;
  function automatic logic signed [LLR_W-1:0] llr_hi(input logic b);
    return b ? -MAG_HI : MAG_HI;
  endfunction
  function automatic logic signed [LLR_W-1:0] llr_lo(input logic b);
    return b ? -MAG_LO : MAG_LO;
  endfunction
endpackage

// File: rtl/hard_llr_seq_if.sv
// hard_llr_seq_if: request/result bundle between the hard decoder and the LLR mapper
interface hard_llr_seq_if
  import hard_llr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W = $clog2(DATA_WIDTH + 1) + 1
);
  logic start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] a_in;
  logic mode_in;
  logic busy;
  logic [DATA_WIDTH-1:0][LLR_W-1:0] llr_out;
  logic done;
  logic syndrome_ok;
  logic cfg_err;
  modport master (output start, data_in, len_in, a_in, mode_in,
                  input busy, llr_out, done, syndrome_ok, cfg_err);
  modport slave (input start, data_in, len_in, a_in, mode_in,
                 output busy, llr_out, done, syndrome_ok, cfg_err);
endinterface

// File: rtl/hard_llr_seq_vt_mod_acc.sv
// vt_mod_acc: registered accumulator adding inc modulo modulus with one conditional subtract
module vt_mod_acc #(
  parameter int W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic [W-1:0] inc,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] acc
);
  logic [W-1:0] acc_q, acc_d;
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, inc};
    acc_d = clr ? '0
          : !en ? acc_q
          : (sum >= {1'b0, modulus}) ? W'(sum - {1'b0, modulus})
          : sum[W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/hard_llr_seq.sv
// hard_llr_seq: walks a hard codeword bit by bit, emitting LLRs and checking its VT residue
module hard_llr_seq
  import hard_llr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W = $clog2(DATA_WIDTH + 1) + 1
) (
  input logic clk,
  input logic rst_n,
  hard_llr_seq_if.slave bus
);
  localparam int IW = $clog2(DATA_WIDTH);
  state_t state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d, a_q, a_d, acc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0][LLR_W-1:0] llr_q, llr_d;
  logic mode_q, mode_d, syn_q, syn_d, cfg_q, cfg_d;
  logic clr, en, bad, bit_v;
  assign bit_v = data_q[idx_q[IW-1:0]];
  vt_mod_acc #(.W(LEN_W)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .en(en),
    .inc(idx_q + 1'b1),
    .modulus(len_q + 1'b1),
    .acc(acc)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    a_d = a_q;
    data_d = data_q;
    mode_d = mode_q;
    llr_d = llr_q;
    syn_d = syn_q;
    cfg_d = cfg_q;
    clr = 1'b0;
    en = 1'b0;
    bad = bus.len_in == '0 || bus.len_in > LEN_W'(DATA_WIDTH) || bus.a_in > bus.len_in;
    case (state_q)
      IDLE: if (bus.start) begin
        data_d = bus.data_in;
        len_d = bus.len_in;
        a_d = bus.a_in;
        mode_d = bus.mode_in;
        llr_d = '0;
        syn_d = 1'b0;
        cfg_d = bad;
        idx_d = '0;
        clr = 1'b1;
        // an illegal config still spends one cycle in CHECK so done keeps a fixed 2-cycle latency
        state_d = bad ? CHECK : ACCUM;
      end
      ACCUM: begin
        llr_d[idx_q[IW-1:0]] = llr_hi(bit_v);
        en = bit_v;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == len_q - 1'b1) ? CHECK : ACCUM;
      end
      CHECK: begin
        syn_d = !cfg_q && acc == a_q;
        for (int i = 0; i < DATA_WIDTH; i++)
          if (mode_q && !cfg_q && !syn_d && LEN_W'(i) < len_q) llr_d[i] = llr_lo(data_q[i]);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      a_q <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      llr_q <= '0;
      syn_q <= 1'b0;
      cfg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      a_q <= a_d;
      data_q <= data_d;
      mode_q <= mode_d;
      llr_q <= llr_d;
      syn_q <= syn_d;
      cfg_q <= cfg_d;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.llr_out = llr_q;
  assign bus.syndrome_ok = syn_q;
  assign bus.cfg_err = cfg_q;
endmodule

// File: tb/tb_hard_llr_seq.sv
// tb_hard_llr_seq: scoreboard bench; driver queues model results, monitor checks each done pulse
module tb_hard_llr_seq;
  localparam int DW = 8;
  localparam int LW = 5;
  typedef struct packed {
    logic ok;
    logic cfg;
    logic [31:0] at;
    logic [31:0] nb;
    logic [DW-1:0][31:0] llr;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int busy_run = 0;
  int ncmp = 0;
  int nfail = 0;
  exp_t q[$];
  hard_llr_seq_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();
  hard_llr_seq #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] d, input int l, input int a, input logic m, input int base);
    exp_t e;
    int s, mag;
    e = '0;
    s = 0;
    e.cfg = l == 0 || l > DW || a > l;
    if (!e.cfg) begin
      for (int i = 0; i < l; i++) s += (i + 1) * int'(d[i]);
      e.ok = (s % (l + 1)) == a;
      mag = (m && !e.ok) ? (1 << 21) : (1 << 23);
      for (int i = 0; i < l; i++) e.llr[i] = d[i] ? -mag : mag;
    end
    e.nb = e.cfg ? 2 : l + 2;
    e.at = base + e.nb;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) busy_run = 0;
    else begin
      busy_run = bus.busy ? busy_run + 1 : 0;
      if (bus.done) begin
        if (q.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("syndrome_ok", 64'(bus.syndrome_ok), 64'(e.ok));
          chk("cfg_err", 64'(bus.cfg_err), 64'(e.cfg));
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("busy_cycles", 64'(busy_run), 64'(e.nb));
          for (int i = 0; i < DW; i++) chk($sformatf("llr[%0d]", i), 64'(bus.llr_out[i]), 64'(e.llr[i]));
        end
      end
    end
  end

  task automatic issue(input logic [DW-1:0] d, input int l, input int a, input logic m);
    @(negedge clk);
    bus.start = 1;
    bus.data_in = d;
    bus.len_in = LW'(l);
    bus.a_in = LW'(a);
    bus.mode_in = m;
    q.push_back(model(d, l, a, m, cyc));
    @(negedge clk);
    bus.start = 0;
    bus.data_in = DW'($urandom);
    bus.len_in = LW'($urandom);
    bus.a_in = LW'($urandom);
    bus.mode_in = 1'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL timeout: %0d results outstanding", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_syn"}, 64'(bus.syndrome_ok), 0);
    chk({tag, "_cfg"}, 64'(bus.cfg_err), 0);
    chk({tag, "_llr"}, 64'(|bus.llr_out), 0);
  endtask

  initial begin
    bus.start = 0;
    bus.data_in = '0;
    bus.len_in = '0;
    bus.a_in = '0;
    bus.mode_in = 0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1;
    @(negedge clk);
    issue(8'b0000_0110, 4, 0, 0); drain();
    issue(8'b0000_0110, 4, 1, 1); drain();
    issue(8'b0000_0110, 4, 1, 0); drain();
    issue(8'hFF, 8, 0, 0); drain();
    issue(8'hFF, 8, 0, 1); drain();
    issue(8'h5A, 0, 0, 1); drain();
    issue(8'h5A, 9, 0, 1); drain();
    issue(8'b0000_0110, 4, 5, 1); drain();
    issue(8'b0000_0110, 4, 0, 0);
    bus.start = 1;
    bus.data_in = 8'hF1;
    bus.len_in = 3;
    @(negedge clk);
    bus.start = 0;
    drain();
    issue(8'b0000_0110, 4, 1, 1);
    rst_n = 0;
    q.delete();
    #1;
    chk_idle("abort");
    @(negedge clk);
    rst_n = 1;
    issue(8'b1001_0011, 8, 3, 1); drain();
    for (int n = 0; n < 40; n++) begin
      int l, a;
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, DW);
      a = $urandom_range(0, l + 1);
      issue(DW'($urandom), l, a, 1'($urandom));
      drain();
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
